keypad_digit_entry: RTL and testbench

//  Parametrised, clocked successor of the 9x4 keypad priority encoder.
//  - Synchronises and debounces a one-hot-ish raw key vector; highest index wins.
//  - Emits one registered key code per press, with a key_valid strobe and an active-low loadn strobe.
//  - Shifts BCD digits into an N-digit entry buffer that feeds the microwave timer load path.

---
 rtl/keypad_pkg.sv | 14 +
 rtl/keypad_prio_enc.sv | 20 ++
 rtl/keypad_digit_entry.sv | 139 +++++++++++++
 tb/tb_keypad_digit_entry.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the keypad digit-entry block.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned MAX_DIGIT = 9;

    // Bits needed to hold the values 0..n (never less than one bit).
    function automatic int unsigned count_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/keypad_prio_enc.sv
// Combinational priority encoder: highest set line wins, any flags a press.
module keypad_prio_enc #(
    parameter int unsigned N_KEYS = 10,
    parameter int unsigned CODE_W = 4
) (
    input  logic [N_KEYS-1:0] d_in,
    output logic [CODE_W-1:0] d_out,
    output logic              any
);

    always_comb begin
        d_out = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (d_in[i]) d_out = CODE_W'(i);
        end
    end

    assign any = |d_in;

endmodule

// File: rtl/keypad_digit_entry.sv
// Debounced keypad front end: one registered code per press, BCD digits shifted
// into an N-digit entry buffer for the timer load path.
module keypad_digit_entry
    import keypad_pkg::*;
#(
    parameter int unsigned N_KEYS       = 10,
    parameter int unsigned CODE_W       = 4,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned N_DIGITS     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           clear,
    input  logic [N_KEYS-1:0]              keys_in,
    output logic [CODE_W-1:0]              key_code,
    output logic                           key_valid,
    output logic                           loadn,
    output logic [DIGIT_W*N_DIGITS-1:0]    digits,
    output logic [count_w(N_DIGITS)-1:0]   digit_count,
    output logic                           full
);

    localparam int unsigned BUF_W  = DIGIT_W * N_DIGITS;
    localparam int unsigned CNT_W  = count_w(DEBOUNCE_CYC);
    localparam int unsigned DCNT_W = count_w(N_DIGITS);

    logic [N_KEYS-1:0] sync1, sync2;
    logic [CODE_W-1:0] code_c, cand, cand_nxt;
    logic              any_c, accept_c, is_digit_c;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    state_t            state, state_nxt;
    logic [BUF_W-1:0]  digits_nxt;
    logic [DCNT_W-1:0] count_nxt;

    // Two-flop synchroniser for the asynchronous key lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys_in;
            sync2 <= sync1;
        end
    end

    keypad_prio_enc #(
        .N_KEYS (N_KEYS),
        .CODE_W (CODE_W)
    ) u_enc (
        .d_in  (sync2),
        .d_out (code_c),
        .any   (any_c)
    );

    // Press/release debounce: cnt counts stable-press cycles in DEBOUNCE and
    // consecutive released cycles in HELD.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        accept_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_c && enable) begin
                    state_nxt = DEBOUNCE;
                    cand_nxt  = code_c;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!any_c || (code_c != cand) || !enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYC)) begin
                    accept_c  = 1'b1;
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (any_c) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign is_digit_c = (cand <= CODE_W'(MAX_DIGIT));

    // Entry buffer update; clear beats a same-cycle digit.
    always_comb begin
        digits_nxt = digits;
        count_nxt  = digit_count;
        if (clear) begin
            digits_nxt = '0;
            count_nxt  = '0;
        end else if (accept_c && is_digit_c && !full) begin
            digits_nxt = (digits << DIGIT_W) | BUF_W'(DIGIT_W'(cand));
            count_nxt  = digit_count + DCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            loadn       <= 1'b1;
            digits      <= '0;
            digit_count <= '0;
            full        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cand        <= cand_nxt;
            key_valid   <= accept_c;
            loadn       <= ~accept_c;
            digits      <= digits_nxt;
            digit_count <= count_nxt;
            full        <= (count_nxt == DCNT_W'(N_DIGITS));
            if (accept_c) key_code <= cand;
        end
    end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Scoreboard bench for keypad_digit_entry: directed presses push expected
// pulses, a negedge monitor pops and compares every key_valid pulse.
module tb_keypad_digit_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, clear;
    logic [9:0]  keys_in;
    logic [3:0]  key_code;
    logic        key_valid, loadn, full;
    logic [15:0] digits;
    logic [2:0]  digit_count;

    logic        enable12, clear12;
    logic [11:0] keys12;
    logic [3:0]  key_code12;
    logic        key_valid12, loadn12, full12;
    logic [15:0] digits12;
    logic [2:0]  digit_count12;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int code;
        int dig;
        int cnt;
        int fl;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    keypad_digit_entry dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear       (clear),
        .keys_in     (keys_in),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .loadn       (loadn),
        .digits      (digits),
        .digit_count (digit_count),
        .full        (full)
    );

    keypad_digit_entry #(.N_KEYS(12)) dut12 (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable12),
        .clear       (clear12),
        .keys_in     (keys12),
        .key_code    (key_code12),
        .key_valid   (key_valid12),
        .loadn       (loadn12),
        .digits      (digits12),
        .digit_count (digit_count12),
        .full        (full12)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got key_code=%0d digits=0x%0h expected no pulse (cycle %0d)",
                         key_code, digits, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_code",   32'(key_code),    32'(mon_e.code));
                check("pulse_loadn",  32'(loadn),       32'd0);
                check("pulse_digits", 32'(digits),      32'(mon_e.dig));
                check("pulse_count",  32'(digit_count), 32'(mon_e.cnt));
                check("pulse_full",   32'(full),        32'(mon_e.fl));
                if (mon_e.at >= 0) check("pulse_latency", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    task automatic press(input int k, input bit exp_pulse, input int code,
                         input int dig, input int cnt, input int fl);
        @(negedge clk);
        if (exp_pulse) sb.push_back('{code, dig, cnt, fl, -1});
        keys_in = 10'(1) << k;
        repeat (10) @(negedge clk);
        keys_in = '0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait12(output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (key_valid12) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_code"},    32'(key_code),    32'd0);
        check({tag, "_key_valid"},   32'(key_valid),   32'd0);
        check({tag, "_loadn"},       32'(loadn),       32'd1);
        check({tag, "_digits"},      32'(digits),      32'd0);
        check({tag, "_digit_count"}, 32'(digit_count), 32'd0);
        check({tag, "_full"},        32'(full),        32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst_n    = 1'b0;
        enable   = 1'b1;
        clear    = 1'b0;
        keys_in  = '0;
        enable12 = 1'b1;
        clear12  = 1'b0;
        keys12   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single press of key 3 with latency check
        @(negedge clk);
        sb.push_back('{3, 'h0003, 1, 0, cyc + 7});
        keys_in = 10'h008;
        repeat (10) @(negedge clk);
        keys_in = '0;
        repeat (10) @(negedge clk);

        // 2: fill the buffer, then overflow
        do_clear();
        press(1, 1, 1, 'h0001, 1, 0);
        press(2, 1, 2, 'h0012, 2, 0);
        press(3, 1, 3, 'h0123, 3, 0);
        press(4, 1, 4, 'h1234, 4, 1);
        press(5, 1, 5, 'h1234, 4, 1);
        check("full_after_overflow", 32'(full), 32'd1);

        // 3: bouncing 10'h201, then stable -> key 9, buffer full so unchanged
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            keys_in = 10'h201;
            repeat (2) @(negedge clk);
            keys_in = '0;
            repeat (2) @(negedge clk);
        end
        press(9, 1, 9, 'h1234, 4, 1);
        check("bounce_count", 32'(digit_count), 32'd4);

        // 4: long hold with a short release glitch -> one pulse
        do_clear();
        @(negedge clk);
        sb.push_back('{7, 'h0007, 1, 0, -1});
        keys_in = 10'h080;
        repeat (20) @(negedge clk);
        keys_in = '0;
        repeat (2) @(negedge clk);
        keys_in = 10'h080;
        repeat (28) @(negedge clk);
        keys_in = '0;
        repeat (10) @(negedge clk);

        // 5a: clear in the accept cycle drops the digit but keeps the pulse
        @(negedge clk);
        sb.push_back('{5, 0, 0, 0, cyc + 7});
        keys_in = 10'h020;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (4) @(negedge clk);
        keys_in = '0;
        repeat (10) @(negedge clk);
        check("clear_win_digits", 32'(digits), 32'd0);

        // 5b: enable dropped mid-debounce -> no pulse
        @(negedge clk);
        keys_in = 10'h040;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        keys_in = '0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        check("enable_low_count", 32'(digit_count), 32'd0);

        // 6a: async reset mid-debounce
        press(8, 1, 8, 'h0008, 1, 0);
        @(negedge clk);
        keys_in = 10'h008;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_debounce");
        keys_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 6b: async reset mid-held, key still down after reset -> new press
        @(negedge clk);
        sb.push_back('{2, 'h0002, 1, 0, cyc + 7});
        keys_in = 10'h004;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_held");
        @(negedge clk);
        sb.push_back('{2, 'h0002, 1, 0, -1});
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        keys_in = '0;
        repeat (10) @(negedge clk);

        // 6c: twelve-key variant, function key 11 leaves the buffer alone
        @(negedge clk);
        keys12 = 12'h004;
        wait12(got);
        check("k12_digit_seen",  32'(got),           32'd1);
        check("k12_digit_code",  32'(key_code12),    32'd2);
        check("k12_digit_buf",   32'(digits12),      32'h0002);
        keys12 = '0;
        repeat (10) @(negedge clk);
        keys12 = 12'h800;
        wait12(got);
        check("k12_func_seen",   32'(got),           32'd1);
        check("k12_func_code",   32'(key_code12),    32'd11);
        check("k12_func_loadn",  32'(loadn12),       32'd0);
        check("k12_func_buf",    32'(digits12),      32'h0002);
        check("k12_func_count",  32'(digit_count12), 32'd1);
        keys12 = '0;
        repeat (10) @(negedge clk);

        check("pending_pulses", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
